packed_subtractor: RTL

PACKED_SUBTRACTOR -- requirements
Module: packed_subtractor

---
 rtl/packed_subtractor.sv | 125 ++++++++++++
 1 files changed

// File: rtl/packed_subtractor.sv
// Packed 32-bit subtractor: 2x16, 4x8 or 1x32 lanes, two-stage pipeline with valid/ready handshake.
// Define PACKED_SUBTRACTOR_SAT_EN to clamp underflowing lanes to zero (unsigned saturation).
module packed_subtractor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PS_A_i,
  input  logic [31:0] PS_B_i,
  input  logic [1:0]  PS_OP_i,
  input  logic        PS_BORROW_i,
  input  logic        PS_VALID_i,
  output logic        PS_READY_o,
  output logic [31:0] PS_R_o,
  output logic [3:0]  PS_BORROW_o,
  output logic        PS_VALID_o,
  input  logic        PS_READY_i
);

  // Returns {borrow_out, difference} for one byte segment.
  function automatic logic [8:0] seg_sub(input logic [7:0] a, input logic [7:0] b,
                                         input logic bin);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, ~b} + {8'd0, ~bin};
    return {~s[8], s[7:0]};
  endfunction

`ifdef PACKED_SUBTRACTOR_SAT_EN
  // A lane saturates to zero when its top segment borrows out.
  function automatic logic [31:0] sat_lanes(input logic [31:0] r, input logic [3:0] bo,
                                            input logic [1:0] op);
    logic [31:0] o;
    o = r;
    case (op)
      2'b00: begin
        if (bo[1]) o[15:0]  = 16'd0;
        if (bo[3]) o[31:16] = 16'd0;
      end
      2'b01: begin
        for (int k = 0; k < 4; k++) if (bo[k]) o[8*k +: 8] = 8'd0;
      end
      default: if (bo[3]) o = 32'd0;
    endcase
    return o;
  endfunction
`endif

  logic        r_vld_p0;
  logic [15:0] r_d_p0;
  logic [15:0] r_ahi_p0;
  logic [15:0] r_bhi_p0;
  logic [1:0]  r_op_p0;
  logic [1:0]  r_bo_p0;

  logic        r_vld_p1;
  logic [31:0] r_r_p1;
  logic [3:0]  r_bo_p1;

  logic        w_load_p1;
  logic        w_adv_p0;
  logic [8:0]  w_s0, w_s1, w_s2, w_s3;
  logic        w_bin1, w_bin2, w_bin3;
  logic [31:0] w_raw;
  logic [31:0] w_res;
  logic [3:0]  w_bo;

  assign w_load_p1  = ~r_vld_p1 | PS_READY_i;
  assign w_adv_p0   = ~r_vld_p0 | w_load_p1;
  assign PS_READY_o = w_adv_p0;

  // Stage 1: byte segments 0 and 1
  assign w_s0   = seg_sub(PS_A_i[7:0], PS_B_i[7:0], PS_BORROW_i);
  assign w_bin1 = (PS_OP_i == 2'b01) ? 1'b0 : w_s0[8];
  assign w_s1   = seg_sub(PS_A_i[15:8], PS_B_i[15:8], w_bin1);

  // Stage 2: byte segments 2 and 3; segment 2 chains only in full-width mode
  assign w_bin2 = r_op_p0[1] ? r_bo_p0[1] : 1'b0;
  assign w_s2   = seg_sub(r_ahi_p0[7:0], r_bhi_p0[7:0], w_bin2);
  assign w_bin3 = (r_op_p0 == 2'b01) ? 1'b0 : w_s2[8];
  assign w_s3   = seg_sub(r_ahi_p0[15:8], r_bhi_p0[15:8], w_bin3);

  assign w_raw = {w_s3[7:0], w_s2[7:0], r_d_p0};
  assign w_bo  = {w_s3[8], w_s2[8], r_bo_p0};
`ifdef PACKED_SUBTRACTOR_SAT_EN
  assign w_res = sat_lanes(w_raw, w_bo, r_op_p0);
`else
  assign w_res = w_raw;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p0 <= 1'b0;
      r_d_p0   <= '0;
      r_ahi_p0 <= '0;
      r_bhi_p0 <= '0;
      r_op_p0  <= '0;
      r_bo_p0  <= '0;
      r_vld_p1 <= 1'b0;
      r_r_p1   <= '0;
      r_bo_p1  <= '0;
    end else begin
      if (w_adv_p0) begin
        r_vld_p0 <= PS_VALID_i;
        if (PS_VALID_i) begin
          r_d_p0   <= {w_s1[7:0], w_s0[7:0]};
          r_ahi_p0 <= PS_A_i[31:16];
          r_bhi_p0 <= PS_B_i[31:16];
          r_op_p0  <= PS_OP_i;
          r_bo_p0  <= {w_s1[8], w_s0[8]};
        end
      end
      // Output register holds while a result waits on backpressure
      if (w_load_p1) begin
        r_vld_p1 <= r_vld_p0;
        if (r_vld_p0) begin
          r_r_p1  <= w_res;
          r_bo_p1 <= w_bo;
        end
      end
    end
  end

  assign PS_R_o      = r_r_p1;
  assign PS_BORROW_o = r_bo_p1;
  assign PS_VALID_o  = r_vld_p1;

endmodule
